// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong load buffer: reader FSM encoding and
// the default data/count widths that must agree with the buffer side.
package ppfifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int BANK_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLAIM   = 2'd1,
        ST_READ    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/ppfifo_skid.sv
// Two-entry synchronous FIFO that absorbs the buffer's one-cycle read latency.
// The caller never pushes when full (net of a same-cycle pop) nor pops when empty.
module ppfifo_skid #(
    parameter int W = 17
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (i_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/ppfifo_reader.sv
// Read-side master for the ping-pong load buffer: claims a filled bank, strobes
// out its words and re-emits them as a valid/ready stream with a last flag.
//
// Handshakes: a stream word transfers on a cycle where o_m_valid & i_m_ready;
// o_m_data/o_m_last hold while o_m_valid & !i_m_ready. A word requested by
// o_rd_strobe in cycle N is sampled from i_rd_data in cycle N+1.
module ppfifo_reader
    import ppfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_rd_ready,
    output logic                      o_rd_activate,
    input  logic [CNT_WIDTH-1:0]      i_rd_size,
    output logic                      o_rd_strobe,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    output logic                      o_m_valid,
    output logic [DATA_WIDTH-1:0]     o_m_data,
    output logic                      o_m_last,
    input  logic                      i_m_ready,
    output logic                      o_busy,
    output logic [BANK_CNT_WIDTH-1:0] o_bank_cnt,
    output logic [1:0]                o_state
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state;
    logic [CNT_WIDTH-1:0]      size_q;
    logic [CNT_WIDTH-1:0]      issued;
    logic [CNT_WIDTH-1:0]      sent;
    logic                      inflight;
    logic                      inflight_last;
    logic                      activate_q;
    logic [BANK_CNT_WIDTH-1:0] bank_cnt;

    logic [1:0]                skid_count;
    logic [DATA_WIDTH:0]       skid_head;

    logic                      claim;
    logic                      m_valid;
    logic                      pop;
    logic [2:0]                occ_now;
    logic [2:0]                count_after;
    logic                      credit_ok;
    logic                      strobe;
    logic                      strobe_last;
    logic [CNT_WIDTH-1:0]      sent_after;
    logic                      done;

    assign claim   = i_en & i_rd_ready;
    assign m_valid = (skid_count != 2'd0);
    assign pop     = m_valid & i_m_ready;

    // Occupancy counts the word still on its way from the RAM. Crediting this
    // cycle's pop keeps the pipe full at one word per clock without ever
    // letting occupancy plus the in-flight word exceed two.
    assign occ_now     = {1'b0, skid_count} + {2'b00, inflight};
    assign count_after = occ_now - {2'b00, pop};
    assign credit_ok   = occ_now < (3'd2 + {2'b00, pop});

    assign strobe      = (state == ST_READ) && (issued < size_q) && credit_ok;
    assign strobe_last = strobe && ((issued + CNT_ONE) == size_q);

    assign sent_after  = pop ? (sent + CNT_ONE) : sent;
    assign done        = (sent_after == size_q) && (count_after == 3'd0);

    ppfifo_skid #(
        .W (DATA_WIDTH + 1)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (inflight),
        .i_push_data ({inflight_last, i_rd_data}),
        .i_pop       (pop),
        .o_head      (skid_head),
        .o_count     (skid_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            size_q        <= '0;
            issued        <= '0;
            sent          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            activate_q    <= 1'b0;
            bank_cnt      <= '0;
        end else begin
            inflight      <= strobe;
            inflight_last <= strobe_last;
            if (strobe) begin
                issued <= issued + CNT_ONE;
            end
            if (pop) begin
                sent <= sent + CNT_ONE;
            end
            case (state)
                ST_IDLE: begin
                    if (claim) begin
                        state      <= ST_CLAIM;
                        size_q     <= i_rd_size;
                        issued     <= '0;
                        sent       <= '0;
                        activate_q <= 1'b1;
                    end
                end
                ST_CLAIM: begin
                    if (!i_rd_ready) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (done) begin
                        state      <= ST_RELEASE;
                        activate_q <= 1'b0;
                    end
                end
                default: begin
                    // The release cycle is itself the idle gap, so a bank that is
                    // already waiting is claimed here for a single-cycle gap.
                    bank_cnt <= bank_cnt + 16'd1;
                    if (claim) begin
                        state      <= ST_CLAIM;
                        size_q     <= i_rd_size;
                        issued     <= '0;
                        sent       <= '0;
                        activate_q <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_rd_activate = activate_q;
    assign o_rd_strobe   = strobe;
    assign o_m_valid     = m_valid;
    assign o_m_data      = skid_head[DATA_WIDTH-1:0];
    assign o_m_last      = skid_head[DATA_WIDTH] & m_valid;
    assign o_busy        = (state != ST_IDLE);
    assign o_bank_cnt    = bank_cnt;
    assign o_state       = state;

endmodule

// File: tb/tb_ppfifo_reader.sv
// Bench for ppfifo_reader: a buffer model that offers banks and answers strobes,
// a scoreboard of expected {last,data} words, table-driven banks plus corner sequences.
module tb_ppfifo_reader;
    import ppfifo_pkg::*;

    localparam int DW = 16;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          en;
    logic          rd_ready;
    logic [CW-1:0] rd_size;
    logic [DW-1:0] rd_data;
    logic          m_ready;
    logic          rd_activate;
    logic          rd_strobe;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [15:0]   bank_cnt;
    logic [1:0]    dbg_state;

    ppfifo_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_rd_ready    (rd_ready),
        .o_rd_activate (rd_activate),
        .i_rd_size     (rd_size),
        .o_rd_strobe   (rd_strobe),
        .i_rd_data     (rd_data),
        .o_m_valid     (m_valid),
        .o_m_data      (m_data),
        .o_m_last      (m_last),
        .i_m_ready     (m_ready),
        .o_busy        (busy),
        .o_bank_cnt    (bank_cnt),
        .o_state       (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int            n_vec  = 0;
    int            n_fail = 0;
    logic [DW:0]   exp_q[$];
    int            offer_size[$];
    logic [DW-1:0] offer_base[$];
    int            cur_size;
    logic [DW-1:0] cur_base;
    int            rd_idx;
    int            ready_mode;
    int            pat_idx;
    int            outstanding;
    int            gap_len;
    int            last_gap;
    logic          prev_act;
    logic          stall_prev;
    logic [DW:0]   stall_word;
    int            n_beats;
    int            n_lasts;
    int            n_strobes;
    int            exp_banks;

    typedef struct {
        int            size;
        logic [DW-1:0] base;
        int            mode;
        int            exp_beats;
        int            exp_lasts;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        offer_size.delete();
        offer_base.delete();
        rd_ready    = 1'b0;
        rd_size     = '0;
        rd_idx      = 0;
        cur_size    = 0;
        outstanding = 0;
        stall_prev  = 1'b0;
        prev_act    = 1'b0;
        gap_len     = 0;
        exp_banks   = 0;
    endtask

    task automatic offer(input int size, input logic [DW-1:0] base);
        offer_size.push_back(size);
        offer_base.push_back(base);
    endtask

    // ---------------- driver: one clock of buffer + sink model ----------------
    task automatic cycle();
        logic        strobe_s;
        logic        hs;
        logic        last_s;
        logic [DW:0] exp_w;
        @(negedge clk);
        strobe_s = rd_strobe;
        hs       = m_valid & m_ready;
        last_s   = m_last;
        if (stall_prev) begin
            check("stall_hold", {13'd0, m_valid, m_last, m_data}, {13'd0, 1'b1, stall_word});
        end
        stall_prev = m_valid & ~m_ready;
        stall_word = {m_last, m_data};
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {15'd0, m_last, m_data}, 32'hFFFF_FFFF);
            end else begin
                exp_w = exp_q.pop_front();
                check("beat", {15'd0, m_last, m_data}, {15'd0, exp_w});
            end
            n_beats++;
            if (m_last) n_lasts++;
            outstanding--;
        end
        if (strobe_s) begin
            outstanding++;
            n_strobes++;
            check("strobe_in_bank", (rd_idx < cur_size) ? 32'd1 : 32'd0, 32'd1);
            check("outstanding_le2", (outstanding <= 2) ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        if (hs && last_s) begin
            check("act_drop_after_last", {31'd0, rd_activate}, 32'd0);
        end
        if (strobe_s) begin
            rd_data = cur_base + DW'(rd_idx);
            rd_idx++;
        end else begin
            rd_data = DW'($urandom);
        end
        if (rd_activate && !prev_act) begin
            last_gap = gap_len;
            gap_len  = 0;
            if (offer_size.size() == 0) begin
                check("claim_without_offer", 32'd1, 32'd0);
            end else begin
                cur_size = offer_size.pop_front();
                cur_base = offer_base.pop_front();
                rd_idx   = 0;
                exp_banks++;
                for (int i = 0; i < cur_size; i++) begin
                    exp_q.push_back({(i == cur_size - 1), cur_base + DW'(i)});
                end
            end
            rd_ready = 1'b0;
        end else begin
            if (!rd_activate) gap_len++;
            if (!rd_ready && offer_size.size() > 0) begin
                rd_ready = 1'b1;
                rd_size  = CW'(offer_size[0]);
            end
        end
        prev_act = rd_activate;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        pat_idx++;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(offer_size.size() == 0 && exp_q.size() == 0 && !busy && !rd_activate)
                   && n < budget);
        check("drain_in_budget", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_activate"}, {31'd0, rd_activate}, 32'd0);
        check({tag, "_strobe"},   {31'd0, rd_strobe},   32'd0);
        check({tag, "_valid"},    {31'd0, m_valid},     32'd0);
        check({tag, "_last"},     {31'd0, m_last},      32'd0);
        check({tag, "_data"},     {16'd0, m_data},      32'd0);
        check({tag, "_busy"},     {31'd0, busy},        32'd0);
        check({tag, "_bank_cnt"}, {16'd0, bank_cnt},    32'd0);
        check({tag, "_state"},    {30'd0, dbg_state},   {30'd0, ST_IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b0;
        int l0;
        int s0;
        tbl[0] = '{size: 4,  base: 16'h00A1, mode: 0, exp_beats: 4,  exp_lasts: 1};
        tbl[1] = '{size: 8,  base: 16'h0100, mode: 1, exp_beats: 8,  exp_lasts: 1};
        tbl[2] = '{size: 0,  base: 16'h0000, mode: 0, exp_beats: 0,  exp_lasts: 0};
        tbl[3] = '{size: 12, base: 16'h3C0,  mode: 2, exp_beats: 12, exp_lasts: 1};

        rst_n      = 1'b0;
        en         = 1'b0;
        m_ready    = 1'b1;
        rd_data    = '0;
        ready_mode = 0;
        pat_idx    = 0;
        n_beats    = 0;
        n_lasts    = 0;
        n_strobes  = 0;
        last_gap   = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b1;

        // Table-driven single banks: basic, backpressure, empty bank, random stall.
        for (int v = 0; v < 4; v++) begin
            b0 = n_beats; l0 = n_lasts; s0 = n_strobes;
            ready_mode = tbl[v].mode;
            pat_idx    = 0;
            offer(tbl[v].size, tbl[v].base);
            run_until_idle(200);
            check("tbl_beats",    32'(n_beats - b0),  32'(tbl[v].exp_beats));
            check("tbl_lasts",    32'(n_lasts - l0),  32'(tbl[v].exp_lasts));
            check("tbl_strobes",  32'(n_strobes - s0), 32'(tbl[v].size));
            check("tbl_bank_cnt", {16'd0, bank_cnt},  32'(exp_banks));
        end

        // Back-to-back banks with the next bank offered right after the ack.
        ready_mode = 0;
        b0 = n_beats; l0 = n_lasts;
        offer(3, 16'h0B00);
        offer(5, 16'h0C00);
        run_until_idle(200);
        check("b2b_beats",    32'(n_beats - b0), 32'd8);
        check("b2b_lasts",    32'(n_lasts - l0), 32'd2);
        check("b2b_gap",      32'(last_gap),     32'd1);
        check("b2b_bank_cnt", {16'd0, bank_cnt}, 32'(exp_banks));

        // Claims blocked while disabled, then taken within one cycle.
        en = 1'b0;
        offer(2, 16'h0D00);
        repeat (5) cycle();
        check("dis_activate", {31'd0, rd_activate}, 32'd0);
        check("dis_busy",     {31'd0, busy},        32'd0);
        check("dis_ready_up", {31'd0, rd_ready},    32'd1);
        en = 1'b1;
        cycle();
        check("en_claim", {31'd0, rd_activate}, 32'd1);
        run_until_idle(100);
        check("en_bank_cnt", {16'd0, bank_cnt}, 32'(exp_banks));

        // Reset in the middle of a bank, then a fresh bank.
        b0 = n_beats;
        offer(6, 16'h0E00);
        for (int i = 0; i < 100 && (n_beats - b0) < 2; i++) cycle();
        check("mid_beats_before_rst", 32'(n_beats - b0), 32'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b0 = n_beats; l0 = n_lasts;
        offer(6, 16'h0F00);
        run_until_idle(200);
        check("post_rst_beats",    32'(n_beats - b0), 32'd6);
        check("post_rst_lasts",    32'(n_lasts - l0), 32'd1);
        check("post_rst_bank_cnt", {16'd0, bank_cnt}, 32'd1);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
